mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 38 +++
 rtl/mux_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and
// default sizing parameters.
package mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int DEF_INPUT_COUNT = 8;
    localparam int DEF_MAX_HOLD    = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-priority-encode: finds the first set bit of
// (i_req & i_mask) searching upward from i_start, wrapping at N-1.
module rr_priority_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_index,
    output logic         o_found
);

    logic [N-1:0] w_cand;
    assign w_cand = i_req & i_mask;

    always_comb begin
        int          w_pos;
        logic [W-1:0] w_idx;
        o_index = '0;
        o_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = int'(i_start) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = W'(w_pos);
            if (w_cand[w_idx]) begin
                o_index = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a downstream mux select. Grants are held until
// done, owner withdrawal, or a hold limit; back-to-back handover has no bubble.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter  int INPUT_COUNT = DEF_INPUT_COUNT,
    parameter  int MAX_HOLD    = DEF_MAX_HOLD,
    localparam int SEL_WIDTH   = $clog2(INPUT_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_COUNT-1:0] req,
    input  logic                   done,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic [INPUT_COUNT-1:0] grant,
    output logic                   grant_valid,
    output logic                   timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(INPUT_COUNT - 1);
    localparam logic [INPUT_COUNT-1:0] ONE      = INPUT_COUNT'(1);

    state_t                 r_state;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [INPUT_COUNT-1:0] r_grant;
    logic                   r_grant_valid;
    logic                   r_timeout;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [SEL_WIDTH-1:0]   r_last_ptr;

    state_t                 w_state_nxt;
    logic [SEL_WIDTH-1:0]   w_sel_nxt;
    logic [INPUT_COUNT-1:0] w_grant_nxt;
    logic                   w_valid_nxt;
    logic                   w_timeout_nxt;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic [SEL_WIDTH-1:0]   w_last_nxt;

    logic [SEL_WIDTH-1:0]   w_base;
    logic [SEL_WIDTH-1:0]   w_start;
    logic [INPUT_COUNT-1:0] w_mask;
    logic [SEL_WIDTH-1:0]   w_pick_idx;
    logic                   w_pick_found;
    logic                   w_limit;
    logic                   w_release;

    // In BUSY the search only matters at release, when last_ptr becomes sel,
    // so the owner is both the rotation base and the masked-out requester.
    assign w_base  = (r_state == ST_BUSY) ? r_sel : r_last_ptr;
    assign w_start = (w_base == LAST_IDX) ? '0 : w_base + SEL_WIDTH'(1);
    assign w_mask  = (r_state == ST_BUSY) ? ~(ONE << r_sel) : '1;

    rr_priority_pick #(
        .N (INPUT_COUNT),
        .W (SEL_WIDTH)
    ) u_pick (
        .i_req   (req),
        .i_mask  (w_mask),
        .i_start (w_start),
        .o_index (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_limit   = (r_hold_cnt == HOLD_LIMIT);
    assign w_release = done | ~req[r_sel] | w_limit;

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_grant_valid;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_last_nxt    = r_last_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_pick_idx;
                    w_grant_nxt = ONE << w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_last_nxt    = r_sel;
                    w_timeout_nxt = w_limit & ~done;
                    w_hold_nxt    = '0;
                    if (w_pick_found) begin
                        w_sel_nxt   = w_pick_idx;
                        w_grant_nxt = ONE << w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
            r_last_ptr    <= LAST_IDX;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_last_ptr    <= w_last_nxt;
        end
    end

    assign sel         = r_sel;
    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (INPUT_COUNT=8, MAX_HOLD=4); outputs are
// sampled on the falling edge, inputs change on the falling edge.
module tb_mux_rr_arbiter;

    localparam int N = 8;
    localparam int H = 4;
    localparam int SW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          done;
    logic [SW-1:0] sel;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic          timeout;

    int vec_cnt;
    int err_cnt;
    logic [31:0] exp_q[$];

    mux_rr_arbiter #(
        .INPUT_COUNT (N),
        .MAX_HOLD    (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_valid, input logic [SW-1:0] exp_sel,
                             input logic [N-1:0] exp_grant, input logic exp_to);
        check({tag, ".valid"},   32'(grant_valid), 32'(exp_valid));
        check({tag, ".sel"},     32'(sel),         32'(exp_sel));
        check({tag, ".grant"},   32'(grant),       32'(exp_grant));
        check({tag, ".timeout"}, 32'(timeout),     32'(exp_to));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) step();
        check_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;

        // done in IDLE has no effect
        done = 1'b1;
        step();
        check_out("idle_done", 1'b0, 3'd0, 8'h00, 1'b0);
        done = 1'b0;

        // first grant, one-cycle latency
        req = 8'h01;
        step();
        check_out("first", 1'b1, 3'd0, 8'h01, 1'b0);
        req = 8'h00;
        step();
        check_out("first_drop", 1'b0, 3'd0, 8'h00, 1'b0);

        // round robin from reset pointer, back-to-back grants
        pulse_reset();
        req = 8'h85;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr.valid", 32'(grant_valid), 32'd1);
            check("rr.sel", 32'(sel), exp_q.pop_front());
            done = 1'b1;
        end
        done = 1'b0;
        req  = 8'h00;
        step();
        check_out("rr_idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // hold limit: grant lasts 4 cycles then timeout pulse, back to IDLE
        req = 8'h10;
        step();
        check_out("to_grant", 1'b1, 3'd4, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("to_hold", 1'b1, 3'd4, 8'h10, 1'b0);
        end
        step();
        check_out("to_pulse", 1'b0, 3'd4, 8'h00, 1'b1);
        step();
        check_out("to_regrant", 1'b1, 3'd4, 8'h10, 1'b0);
        req = 8'h00;
        step();
        check_out("to_idle", 1'b0, 3'd4, 8'h00, 1'b0);

        // owner withdraws while another requester waits
        req = 8'h08;
        step();
        check_out("wd_grant", 1'b1, 3'd3, 8'h08, 1'b0);
        req = 8'h20;
        step();
        check_out("wd_next", 1'b1, 3'd5, 8'h20, 1'b0);
        req = 8'h00;
        step();
        check_out("wd_idle", 1'b0, 3'd5, 8'h00, 1'b0);

        // done coincides with hold limit: no timeout
        req = 8'h02;
        step();
        check_out("co_grant", 1'b1, 3'd1, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("co_hold", 1'b1, 3'd1, 8'h02, 1'b0);
        end
        done = 1'b1;
        step();
        check_out("co_release", 1'b0, 3'd1, 8'h00, 1'b0);
        done = 1'b0;
        step();
        check_out("co_regrant", 1'b1, 3'd1, 8'h02, 1'b0);
        req = 8'h00;
        step();
        check_out("co_idle", 1'b0, 3'd1, 8'h00, 1'b0);

        // asynchronous reset between edges while BUSY
        req = 8'h40;
        step();
        check_out("ar_grant", 1'b1, 3'd6, 8'h40, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("ar_async", 1'b0, 3'd0, 8'h00, 1'b0);
        req = 8'hFF;
        step();
        check_out("ar_held", 1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
        step();
        check_out("ar_first", 1'b1, 3'd0, 8'h01, 1'b0);
        done = 1'b1;
        step();
        check_out("ar_next", 1'b1, 3'd1, 8'h02, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();
        check_out("ar_idle", 1'b0, 3'd1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
